// File: rtl/cordic_issue_sequencer.sv
// Burst issue sequencer for an external CORDIC pipeline: feeds a burst of packed operands one per
// enabled cycle and gathers returned results/squared values in arrival order, with stall timeout.
module cordic_issue_sequencer #(
    parameter int unsigned NUM_OPERANDS      = 2,
    parameter int unsigned CORDIC_DATA_WIDTH = 22,
    parameter int unsigned FLOAT_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 64,
    parameter logic [CORDIC_DATA_WIDTH-1:0] DEFAULT_INPUT = '0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          clk_en,
    input  logic                                          start,
    input  logic [NUM_OPERANDS*CORDIC_DATA_WIDTH-1:0]     operands,
    output logic                                          busy,
    output logic [CORDIC_DATA_WIDTH-1:0]                  pipe_target,
    output logic                                          pipe_start,
    input  logic [CORDIC_DATA_WIDTH-1:0]                  pipe_result,
    input  logic [FLOAT_DATA_WIDTH-1:0]                   pipe_squared,
    input  logic                                          pipe_valid,
    output logic [NUM_OPERANDS*CORDIC_DATA_WIDTH-1:0]     results,
    output logic [NUM_OPERANDS*FLOAT_DATA_WIDTH-1:0]      squared,
    output logic                                          done,
    output logic                                          timeout_err
);

    localparam int unsigned N     = NUM_OPERANDS;
    localparam int unsigned W     = CORDIC_DATA_WIDTH;
    localparam int unsigned FW    = FLOAT_DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_OPERANDS + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_OPERANDS);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StCollect, StDone} state_t;

    state_t             state;
    logic [N*W-1:0]     shadow;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   collect_idx;
    logic [TO_W-1:0]    to_cnt;

    logic [W-1:0]       issue_operand;
    logic [IDX_W-1:0]   collect_next;
    logic [TO_W-1:0]    to_next;
    logic               collect_fire;

    always_comb begin
        issue_operand = DEFAULT_INPUT;
        for (int i = 0; i < N; i++) begin
            if (issue_idx == IDX_W'(i)) begin
                issue_operand = shadow[i*W +: W];
            end
        end
    end

    assign collect_next = collect_idx + 1'b1;
    assign to_next      = to_cnt + 1'b1;
    assign collect_fire = pipe_valid && ((state == StIssue) || (state == StCollect));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            shadow      <= '0;
            issue_idx   <= '0;
            collect_idx <= '0;
            to_cnt      <= '0;
            busy        <= 1'b0;
            pipe_start  <= 1'b0;
            pipe_target <= DEFAULT_INPUT;
            results     <= '0;
            squared     <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    pipe_start  <= 1'b0;
                    pipe_target <= DEFAULT_INPUT;
                    if (start) begin
                        shadow      <= operands;
                        issue_idx   <= '0;
                        collect_idx <= '0;
                        to_cnt      <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    pipe_start  <= 1'b1;
                    pipe_target <= issue_operand;
                    issue_idx   <= issue_idx + 1'b1;
                    if (issue_idx == LAST_IDX) begin
                        state <= StCollect;
                    end
                end
                StCollect: begin
                    pipe_start  <= 1'b0;
                    pipe_target <= DEFAULT_INPUT;
                    if (pipe_valid) begin
                        to_cnt <= '0;
                    end else if (to_next == TO_LIMIT) begin
                        // Stalled pipeline: abandon the burst, keep whatever was collected.
                        to_cnt      <= to_next;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        to_cnt <= to_next;
                    end
                end
                StDone: begin
                    pipe_start  <= 1'b0;
                    pipe_target <= DEFAULT_INPUT;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase

            // Collection overrides the state update above, so the last result ends the burst
            // even if it lands while still issuing.
            if (collect_fire) begin
                for (int i = 0; i < N; i++) begin
                    if (collect_idx == IDX_W'(i)) begin
                        results[i*W +: W]   <= pipe_result;
                        squared[i*FW +: FW] <= pipe_squared;
                    end
                end
                collect_idx <= collect_next;
                if (collect_next == FULL_IDX) begin
                    state <= StDone;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/cordic_issue_sequencer.md
Name: cordic_issue_sequencer

Overview:
Parametrised successor to the two-operand CORDIC feed stage. It accepts a burst of NUM_OPERANDS packed operands, issues them one per enabled cycle into an external cordic_pipeline, and collects the returned results and squared values into packed output vectors. It raises a done pulse when the burst completes and a timeout error if the pipeline stalls. It sits between the control/adder front end and the cordic_pipeline instance, which is external to this block.

Parameters:
NUM_OPERANDS, 2, operands per burst (>=1)
CORDIC_DATA_WIDTH, 22, width of each operand and result
FLOAT_DATA_WIDTH, 32, width of each squared value
TIMEOUT_CYCLES, 64, maximum enabled cycles without a pipe_valid before error (>=1)
DEFAULT_INPUT, 0, value driven on pipe_target when not issuing

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
clk_en  in  1  global enable; all state advances only when high
start  in  1  request to begin a burst
operands  in  NUM_OPERANDS*CORDIC_DATA_WIDTH  operand i at bits [i*W +: W]
busy  out  1  high from accepted start until burst end (done or error)
pipe_target  out  CORDIC_DATA_WIDTH  operand to pipeline
pipe_start  out  1  issue strobe to pipeline
pipe_result  in  CORDIC_DATA_WIDTH  pipeline result
pipe_squared  in  FLOAT_DATA_WIDTH  pipeline squared output
pipe_valid  in  1  pipeline result valid
results  out  NUM_OPERANDS*CORDIC_DATA_WIDTH  collected results, arrival order
squared  out  NUM_OPERANDS*FLOAT_DATA_WIDTH  collected squared values, arrival order
done  out  1  one-cycle pulse, burst complete
timeout_err  out  1  sticky error, pipeline stalled

Behaviour:
- Reset (rst=0, async): state IDLE; counters 0; busy=0, pipe_start=0, pipe_target=DEFAULT_INPUT, results=0, squared=0, done=0, timeout_err=0. Reset mid-burst abandons the burst; results arriving afterwards are ignored.
- clk_en=0: every register holds, including done and pipe_start, and pipe_valid is not sampled. The pipeline shares clk_en.
- States:
  - IDLE: if start&&clk_en, latch operands into a shadow register, clear the issue/collect/timeout counters and timeout_err, set busy=1, go to ISSUE. start is ignored in every other state.
  - ISSUE: each enabled cycle drive pipe_target=shadow[issue_idx] and pipe_start=1 (both registered, appearing the cycle after the state/idx update), then increment issue_idx. After issuing index NUM_OPERANDS-1, go to COLLECT. Operand 0 is issued first, on the first enabled cycle after start acceptance.
  - COLLECT: pipe_start=0 and pipe_target=DEFAULT_INPUT.
  - DONE: done=1 for one enabled cycle, busy=0, then go to IDLE.
- Collection (active in ISSUE and COLLECT): on enabled pipe_valid, store pipe_result into slot collect_idx, store pipe_squared into the same slot of squared, and increment collect_idx. When collect_idx reaches NUM_OPERANDS, go to DONE, whether or not issue is finished. Issue still completes first, because collection of the last result implies all were issued.
- pipe_valid outside ISSUE/COLLECT, or beyond NUM_OPERANDS results, is ignored.
- Timeout: in COLLECT, the counter increments each enabled cycle without pipe_valid and clears on pipe_valid. On reaching TIMEOUT_CYCLES: set timeout_err=1, busy=0, no done pulse, go to IDLE. Partially filled results are kept. timeout_err stays until the next accepted start or reset.
- results/squared are stable between bursts; slots not yet written in the current burst keep their previous values.
- Counter widths: $clog2(NUM_OPERANDS+1) and $clog2(TIMEOUT_CYCLES+1).
- Minimum burst latency: start accept -> done = NUM_OPERANDS + pipeline latency + 1 enabled cycles.

Test Plan:
- NUM_OPERANDS=2, operands {0x000200, 0x000100}, pipeline model latency 5 -> pipe_start high for 2 cycles carrying 0x000100 then 0x000200; results slot0/slot1 match the model; done pulses once; busy low afterwards.
- NUM_OPERANDS=4, clk_en toggled 1/0 every cycle during the burst -> the 4 issues occur only on enabled cycles, no duplicates or skips; results are in arrival order; done asserts after the 4th enabled pipe_valid.
- start held high continuously -> the second burst is accepted only in IDLE after done; the operand change applied mid-burst has no effect on the issued values.
- Pipeline model returns only 1 of 2 results, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 enabled idle cycles; busy=0; no done; slot0 valid; the next start clears timeout_err.
- rst asserted during ISSUE after 1 issue -> all outputs return to reset values immediately (async); late pipe_valid is ignored; a new burst runs cleanly.
- Extra pipe_valid pulse after done, in IDLE -> results unchanged; no done.
